// File: rtl/uart_boot_loader.sv
// Boot sequencer: holds the core in reset while a program image is
// pulled from the UART RX FIFO and written into imem from word 0.
module uart_boot_loader #(
   parameter int IMEM_AW = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               boot_req,
   input  logic               uart_empty,
   input  logic [7:0]         uart_in,
   output logic               uart_rdreq,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_wdata,
   output logic               core_rst,
   output logic               busy,
   output logic [IMEM_AW:0]   words_loaded
);

   typedef enum logic [1:0] {
      LEN,
      LOAD,
      DONE,
      RUN
   } state_t;

   // Depth kept 33 bits wide so it compares cleanly with the 32-bit word count.
   localparam logic [32:0] DEPTH = 33'(1) << IMEM_AW;
   localparam logic [IMEM_AW:0] WL_MAX = {1'b1, {IMEM_AW{1'b0}}};
   localparam logic [IMEM_AW:0] WL_ONE = {{IMEM_AW{1'b0}}, 1'b1};

   state_t             state_q;
   logic [1:0]         byte_cnt_q;
   logic [31:0]        sr_q;
   logic [31:0]        n_q;
   logic [31:0]        wcnt_q;
   logic               we_q;
   logic [IMEM_AW-1:0] addr_q;
   logic [31:0]        wdata_q;
   logic               core_rst_q;
   logic [IMEM_AW:0]   wl_q;

   logic               take;
   logic               word_done;
   logic               fits;
   logic [31:0]        word_d;
   logic [31:0]        wcnt_d;

   // Pop the FIFO head whenever a byte is there and we are still loading.
   assign take = !uart_empty && (state_q == LEN || state_q == LOAD);
   assign uart_rdreq = take;

   // The word completed by the current byte (little-endian, last byte on top).
   assign word_d    = {uart_in, sr_q[31:8]};
   assign word_done = take && (byte_cnt_q == 2'd3);
   assign wcnt_d    = wcnt_q + 32'd1;
   assign fits      = {1'b0, wcnt_q} < DEPTH;

   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign core_rst     = core_rst_q;
   assign busy         = (state_q != RUN);
   assign words_loaded = wl_q;

   // Loader FSM: byte assembly, header capture, imem writes and core release.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LEN;
         byte_cnt_q <= 2'd0;
         sr_q       <= 32'd0;
         n_q        <= 32'd0;
         wcnt_q     <= 32'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         core_rst_q <= 1'b1;
         wl_q       <= '0;
      end else begin
         we_q <= 1'b0;
         if (take) begin
            sr_q       <= word_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
         end
         unique case (state_q)
            LEN: begin
               if (word_done) begin
                  n_q    <= word_d;
                  wcnt_q <= 32'd0;
                  if (word_d == 32'd0) begin
                     state_q <= DONE;
                  end else begin
                     state_q <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (word_done) begin
                  // Words past the end of imem are drained but not written.
                  if (fits) begin
                     we_q    <= 1'b1;
                     addr_q  <= wcnt_q[IMEM_AW-1:0];
                     wdata_q <= word_d;
                     if (wl_q != WL_MAX) begin
                        wl_q <= wl_q + WL_ONE;
                     end
                  end
                  wcnt_q <= wcnt_d;
                  if (wcnt_d == n_q) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q    <= RUN;
               core_rst_q <= 1'b0;
            end
            RUN: begin
               if (boot_req) begin
                  state_q    <= LEN;
                  core_rst_q <= 1'b1;
                  byte_cnt_q <= 2'd0;
                  wcnt_q     <= 32'd0;
                  wl_q       <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a byte FIFO model feeds the
// loader and every imem write is popped against the expected queue.
module tb_uart_boot_loader;

   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          boot_req;
   logic          uart_empty;
   logic [7:0]    uart_in;
   logic          uart_rdreq;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst;
   logic          busy;
   logic [AW:0]   words_loaded;

   uart_boot_loader #(.IMEM_AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .boot_req     (boot_req),
      .uart_empty   (uart_empty),
      .uart_in      (uart_in),
      .uart_rdreq   (uart_rdreq),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_rst     (core_rst),
      .busy         (busy),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int vec = 0;
   int errs = 0;
   int cyc_n = 0;
   int last_pop_cyc = 0;
   int popped = 0;
   bit gaps = 1'b0;

   logic [7:0]     fifo[$];
   logic [AW+31:0] sb[$];

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      vec++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock: present FIFO head, sample pop at negedge, consume at posedge.
   task automatic cyc();
      logic tk;
      uart_empty = (fifo.size() == 0) || (gaps && ($urandom_range(0, 1) == 1));
      uart_in = (fifo.size() != 0) ? fifo[0] : 8'h00;
      @(negedge clk);
      tk = uart_rdreq;
      if (uart_empty) chk("pop_empty", uart_rdreq, 0);
      @(posedge clk);
      if (tk && !rst && fifo.size() != 0) begin
         void'(fifo.pop_front());
         popped++;
         last_pop_cyc = cyc_n;
      end
      cyc_n++;
      #1;
   endtask

   task automatic push32(logic [31:0] w);
      for (int i = 0; i < 4; i++) fifo.push_back(w[8*i +: 8]);
   endtask

   task automatic add_word(logic [31:0] w, int idx);
      push32(w);
      if (idx < (1 << AW)) sb.push_back({idx[AW-1:0], w});
   endtask

   task automatic add_stream(int n);
      push32(n);
      for (int i = 0; i < n; i++) add_word($urandom, i);
   endtask

   task automatic reboot();
      boot_req = 1'b1;
      cyc();
      boot_req = 1'b0;
      chk("boot_core_rst", core_rst, 1);
      chk("boot_busy", busy, 1);
      chk("boot_wl", words_loaded, 0);
   endtask

   // Run until the core is released; release must come 2 cycles after the last pop.
   task automatic wait_run(int budget, int exp_wl);
      int n = 0;
      while (core_rst !== 1'b0 && n < budget) begin
         cyc();
         n++;
      end
      chk("run_timeout", (n < budget), 1);
      chk("rel_lat", cyc_n - last_pop_cyc, 2);
      chk("run_busy", busy, 0);
      chk("run_wl", words_loaded, exp_wl);
      chk("sb_empty", sb.size(), 0);
   endtask

   // Scoreboard: every write must match the next expected {addr, data}.
   always @(negedge clk) begin
      logic [AW+31:0] e;
      if (imem_we === 1'b1) begin
         if (sb.size() == 0) begin
            chk("we_extra", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("we_addr", imem_addr, e[AW+31:32]);
            chk("we_data", imem_wdata, e[31:0]);
            chk("we_lat", cyc_n - last_pop_cyc, 1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      rst = 1'b1;
      boot_req = 1'b0;
      uart_empty = 1'b1;
      uart_in = 8'h00;
      cyc();
      cyc();
      chk("rst_rdreq", uart_rdreq, 0);
      chk("rst_we", imem_we, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_core_rst", core_rst, 1);
      chk("rst_busy", busy, 1);
      chk("rst_wl", words_loaded, 0);
      rst = 1'b0;

      // Two-word program fed every cycle.
      push32(32'd2);
      add_word(32'h00100513, 0);
      add_word(32'h0000006F, 1);
      wait_run(100, 2);

      // Bytes waiting in RUN stay put until boot_req; boot_req in LOAD is ignored.
      add_stream(2);
      p0 = popped;
      repeat (5) cyc();
      chk("run_no_pop", popped - p0, 0);
      chk("run_core_rst", core_rst, 0);
      reboot();
      repeat (6) cyc();
      chk("load_busy", busy, 1);
      boot_req = 1'b1;
      cyc();
      boot_req = 1'b0;
      wait_run(100, 2);

      // Empty image.
      push32(32'd0);
      reboot();
      wait_run(50, 0);

      // Three words with random FIFO stalls.
      add_stream(3);
      gaps = 1'b1;
      reboot();
      wait_run(400, 3);
      gaps = 1'b0;

      // Image longer than imem: extra words drained, not written.
      add_stream(6);
      p0 = popped;
      reboot();
      wait_run(200, 4);
      chk("over_popped", popped - p0, 28);
      chk("over_fifo", fifo.size(), 0);

      // Reset in the middle of word 1.
      push32(32'd2);
      add_word(32'h12345678, 0);
      fifo.push_back(8'hAA);
      fifo.push_back(8'hBB);
      reboot();
      p0 = 0;
      while (fifo.size() != 0 && p0 < 50) begin
         cyc();
         p0++;
      end
      chk("mid_drain", fifo.size(), 0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mrst_we", imem_we, 0);
      chk("mrst_addr", imem_addr, 0);
      chk("mrst_wdata", imem_wdata, 0);
      chk("mrst_core_rst", core_rst, 1);
      chk("mrst_busy", busy, 1);
      chk("mrst_wl", words_loaded, 0);
      chk("mrst_sb", sb.size(), 0);
      push32(32'd2);
      add_word(32'hCAFEF00D, 0);
      add_word(32'h0BADBEEF, 1);
      wait_run(100, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
